// File: rtl/spi_mem_port_pkg.sv
// Shared definitions for the SPI memory access port: default widths,
// frame layout constant and FSM state encoding.
package spi_mem_port_pkg;

  // Existing datapath width and per-target memory address width.
  localparam int unsigned DATAPATH_W = 8;
  localparam int unsigned MEM_ADDR_W = 4;

  // Frame bit index (0 = first bit after chip select) carrying R/W, 1 = read.
  localparam int unsigned RW_BIT_IDX = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_COMMIT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-bit 2-flop synchronizer with rise/fall edge detection on the
// synchronized values. Each bit has its own reset level.
module spi_sync #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  // Two synchronizing flops plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_mem_port.sv
// SPI slave giving an external master read/write access to the instruction
// or data memory while the processor is halted.
module spi_mem_port
  import spi_mem_port_pkg::*;
#(
  parameter int unsigned DATA_W = DATAPATH_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_in,
  input  logic              mosi_in,
  input  logic              csi_n_in,
  input  logic              csd_n_in,
  output logic              miso_out,
  input  logic              proc_busy_in,
  output logic              mem_sel_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic              mem_wen_out,
  output logic              mem_ren_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              wr_done_out,
  output logic              err_out,
  output logic              busy_out
);

  localparam int unsigned      CNT_W      = $clog2(ADDR_W + DATA_W + 3);
  localparam logic [CNT_W-1:0] CMD_BITS   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(1 + ADDR_W + DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(2 + ADDR_W + DATA_W);
  localparam int unsigned      RW_POS     = ADDR_W - RW_BIT_IDX;

  logic [3:0] sync_q, sync_rise, sync_fall;
  logic       mosi_q, csi_q, csd_q, sck_rise, sck_fall;
  logic       cs_high, cs_both_low, abort, frame_start;
  logic       unused_sync;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W:0]     cmd_sr;
  logic [DATA_W-1:0]   wdata_sr;
  logic [DATA_W-1:0]   tx_sr;
  logic [1:0]          arm_cnt;
  logic                ren_d;
  logic                ren_set, wen_set, err_set, cmd_done;

  // Bit order {mosi, csd_n, csi_n, sck}; chip selects reset to deasserted.
  spi_sync #(
    .W       (4),
    .RST_VAL (4'b0110)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({mosi_in, csd_n_in, csi_n_in, sck_in}),
    .q    (sync_q),
    .rise (sync_rise),
    .fall (sync_fall)
  );

  assign sck_rise    = sync_rise[0];
  assign sck_fall    = sync_fall[0];
  assign csi_q       = sync_q[1];
  assign csd_q       = sync_q[2];
  assign mosi_q      = sync_q[3];
  assign unused_sync = ^{sync_q[0], sync_rise[3:1], sync_fall[3:1]};

  assign cs_high     = csi_q & csd_q;
  assign cs_both_low = ~csi_q & ~csd_q;
  assign abort       = cs_both_low | proc_busy_in;

  // A frame start needs chip select seen high for 3 cycles first. The
  // synchronizer resets to "high", so a select still held low across
  // reset only looks high for 2 cycles and never arms a new frame.
  assign frame_start = (arm_cnt == 2'd3) & ~cs_high;

  assign busy_out = (state != ST_IDLE);
  assign miso_out = (state == ST_RDATA) & tx_sr[DATA_W-1];

  // Next-state and one-cycle strobe requests.
  always_comb begin
    state_next = state;
    ren_set    = 1'b0;
    wen_set    = 1'b0;
    err_set    = 1'b0;
    cmd_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_start) state_next = abort ? ST_DRAIN : ST_CMD;
      end
      ST_CMD: begin
        if (abort) begin
          state_next = ST_DRAIN;
        end else if (cs_high) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end else if (cnt == CMD_BITS) begin
          cmd_done   = 1'b1;
          ren_set    = cmd_sr[RW_POS];
          state_next = cmd_sr[RW_POS] ? ST_RDATA : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (abort) begin
          state_next = ST_DRAIN;
        end else if (cs_high) begin
          if (cnt == FRAME_BITS) begin
            state_next = ST_COMMIT;
            wen_set    = 1'b1;
          end else begin
            state_next = ST_IDLE;
            err_set    = 1'b1;
          end
        end else if (cnt == CNT_MAX) begin
          state_next = ST_DRAIN;
        end
      end
      ST_RDATA: begin
        if (abort)        state_next = ST_DRAIN;
        else if (cs_high) state_next = ST_IDLE;
      end
      ST_COMMIT: state_next = ST_IDLE;
      ST_DRAIN: begin
        if (cs_high) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, strobes, bit counter, shift registers and held memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      cmd_sr        <= '0;
      wdata_sr      <= '0;
      tx_sr         <= '0;
      arm_cnt       <= '0;
      ren_d         <= 1'b0;
      mem_sel_out   <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_wen_out   <= 1'b0;
      mem_ren_out   <= 1'b0;
      wr_done_out   <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      state       <= state_next;
      mem_ren_out <= ren_set;
      mem_wen_out <= wen_set;
      wr_done_out <= wen_set;
      err_out     <= err_set;
      ren_d       <= mem_ren_out;

      if (!cs_high)             arm_cnt <= '0;
      else if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;

      if (state == ST_IDLE && frame_start) begin
        cnt         <= '0;
        cmd_sr      <= '0;
        wdata_sr    <= '0;
        mem_sel_out <= csi_q;
      end else if (sck_rise && (state == ST_CMD || state == ST_WDATA ||
                                state == ST_RDATA)) begin
        if (cnt != CNT_MAX)     cnt      <= cnt + CNT_W'(1);
        if (state == ST_CMD)    cmd_sr   <= {cmd_sr[ADDR_W-1:0], mosi_q};
        if (state == ST_WDATA)  wdata_sr <= {wdata_sr[DATA_W-2:0], mosi_q};
      end

      if (cmd_done) mem_addr_out  <= cmd_sr[ADDR_W-1:0];
      if (wen_set)  mem_wdata_out <= wdata_sr;

      // The fall that ends the last command bit must not shift: only falls
      // after a data bit has been clocked advance the TX register.
      if (ren_d && state == ST_RDATA)
        tx_sr <= mem_rdata_in;
      else if (state == ST_RDATA && sck_fall && cnt > CMD_BITS)
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_mem_port.sv
// Self-checking bench for spi_mem_port: a frame-level model predicts the
// memory/err events of each frame and a per-cycle compare process checks
// every strobe against that prediction.
module tb_spi_mem_port;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic       sel;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk, rst, sck, mosi, csi_n, csd_n, proc_busy;
  logic       miso_out, mem_sel_out, mem_wen_out, mem_ren_out;
  logic       wr_done_out, err_out, busy_out;
  logic [3:0] mem_addr_out;
  logic [7:0] mem_wdata_out, mem_rdata_in;

  logic [7:0] env_i [16];
  logic [7:0] env_d [16];
  logic [7:0] ref_i [16];
  logic [7:0] ref_d [16];

  ev_t  evq [$];
  ev_t  ev;
  int   kind_act;
  int   checks = 0;
  int   failures = 0;
  int   wen_cnt = 0, ren_cnt = 0, err_cnt = 0;
  logic       cap_wsel, cap_rsel;
  logic [3:0] cap_waddr, cap_raddr;
  logic [7:0] cap_wdata, miso_cap;

  spi_mem_port #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .sck_in        (sck),
    .mosi_in       (mosi),
    .csi_n_in      (csi_n),
    .csd_n_in      (csd_n),
    .miso_out      (miso_out),
    .proc_busy_in  (proc_busy),
    .mem_sel_out   (mem_sel_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_wen_out   (mem_wen_out),
    .mem_ren_out   (mem_ren_out),
    .mem_rdata_in  (mem_rdata_in),
    .wr_done_out   (wr_done_out),
    .err_out       (err_out),
    .busy_out      (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: registered read with one-cycle latency.
  always @(posedge clk) begin
    if (mem_ren_out) mem_rdata_in <= mem_sel_out ? env_d[mem_addr_out] : env_i[mem_addr_out];
    if (mem_wen_out) begin
      if (mem_sel_out) env_d[mem_addr_out] <= mem_wdata_out;
      else             env_i[mem_addr_out] <= mem_wdata_out;
    end
  end

  // Per-cycle compare of DUT strobes against the predicted event queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (!busy_out) chk("miso_idle", 32'(miso_out), 32'd0);
      if (mem_wen_out || mem_ren_out || err_out || wr_done_out) begin
        chk("wr_done_with_wen", 32'(wr_done_out), 32'(mem_wen_out));
        chk("one_strobe", 32'(mem_wen_out) + 32'(mem_ren_out) + 32'(err_out), 32'd1);
        if (mem_wen_out) begin
          wen_cnt++;
          cap_wsel = mem_sel_out; cap_waddr = mem_addr_out; cap_wdata = mem_wdata_out;
        end
        if (mem_ren_out) begin
          ren_cnt++;
          cap_rsel = mem_sel_out; cap_raddr = mem_addr_out;
        end
        if (err_out) err_cnt++;
        if (evq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual wen=%0b ren=%0b err=%0b required=none at %0t",
                   mem_wen_out, mem_ren_out, err_out, $time);
        end else begin
          ev = evq.pop_front();
          kind_act = mem_wen_out ? K_WR : (mem_ren_out ? K_RD : K_ERR);
          chk("event_kind", kind_act, ev.kind);
          if (ev.kind != K_ERR && kind_act == ev.kind) begin
            chk("event_sel", 32'(mem_sel_out), 32'(ev.sel));
            chk("event_addr", 32'(mem_addr_out), 32'(ev.addr));
            if (ev.kind == K_WR) chk("event_wdata", 32'(mem_wdata_out), 32'(ev.data));
          end
        end
      end
    end
  end

  // Drive one frame and predict its outcome from the frame rules.
  // bits holds the frame MSB-first in its low n bits; *_at = -1 disables.
  task automatic run_frame(input bit use_csd, input logic [15:0] bits, input int n,
                           input int both_at, input int busy_at, input int rst_at);
    ev_t        e;
    logic       is_rd;
    logic [3:0] a;
    logic [7:0] d, word;
    int         abort_at;
    is_rd = bits[n-1];
    a = '0;
    d = '0;
    for (int i = 0; i < 4; i++) if (1 + i < n) a[3-i] = bits[n-2-i];
    for (int j = 0; j < 8; j++) if (5 + j < n) d[7-j] = bits[n-6-j];
    abort_at = -1;
    if (both_at >= 0 && both_at < n) abort_at = both_at;
    if (busy_at >= 0 && busy_at < n && (abort_at < 0 || busy_at < abort_at)) abort_at = busy_at;
    word  = use_csd ? ref_d[a] : ref_i[a];
    e.sel = use_csd;
    e.addr = a;
    e.data = d;
    if (rst_at >= 0) begin
      // dropped silently
    end else if (abort_at >= 0) begin
      if (is_rd && abort_at >= 5) begin e.kind = K_RD; evq.push_back(e); end
      e.kind = K_ERR; evq.push_back(e);
    end else if (is_rd) begin
      e.kind = (n < 5) ? K_ERR : K_RD;
      evq.push_back(e);
    end else if (n == 13) begin
      e.kind = K_WR; evq.push_back(e);
      if (use_csd) ref_d[a] = d; else ref_i[a] = d;
    end else begin
      e.kind = K_ERR; evq.push_back(e);
    end

    miso_cap = '0;
    if (busy_at == 0) proc_busy = 1'b1;
    if (both_at == 0) begin csi_n = 1'b0; csd_n = 1'b0; end
    else if (use_csd) csd_n = 1'b0;
    else              csi_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && k == both_at) begin csi_n = 1'b0; csd_n = 1'b0; end
      if (k > 0 && k == busy_at) proc_busy = 1'b1;
      if (k == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("busy_after_rst", 32'(busy_out), 32'd0);
      end
      mosi = bits[n-1-k];
      repeat (4) @(negedge clk);
      if (is_rd && k >= 5 && k <= 12 && rst_at < 0 && abort_at < 0) begin
        miso_cap[12-k] = miso_out;
        chk("miso_bit", 32'(miso_out), 32'(word[12-k]));
      end
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    csi_n = 1'b1;
    csd_n = 1'b1;
    proc_busy = 1'b0;
    mosi = 1'b0;
    for (int t = 0; t < 60 && evq.size() != 0; t++) @(negedge clk);
    chk("events_pending", evq.size(), 32'd0);
    evq.delete();
    repeat (8) @(negedge clk);
    chk("busy_idle", 32'(busy_out), 32'd0);
    if (rst_at < 0 && abort_at < 0 && ((is_rd && n >= 5) || (!is_rd && n == 13))) begin
      chk("hold_addr", 32'(mem_addr_out), 32'(a));
      chk("hold_sel", 32'(mem_sel_out), 32'(use_csd));
      if (!is_rd) chk("hold_wdata", 32'(mem_wdata_out), 32'(d));
    end
  endtask

  task automatic chk_deltas(input int w0, input int r0, input int e0,
                            input int dw, input int dr, input int de);
    chk("wen_count", wen_cnt - w0, dw);
    chk("ren_count", ren_cnt - r0, dr);
    chk("err_count", err_cnt - e0, de);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, r0, e0;
    for (int i = 0; i < 16; i++) begin
      env_i[i] = 8'(i * 17);
      env_d[i] = 8'(8'hF0 ^ i);
    end
    env_d[3] = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      ref_i[i] = env_i[i];
      ref_d[i] = env_d[i];
    end
    mem_rdata_in = '0;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; csi_n = 1'b1; csd_n = 1'b1; proc_busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(miso_out), 32'd0);
    chk("rst_sel", 32'(mem_sel_out), 32'd0);
    chk("rst_addr", 32'(mem_addr_out), 32'd0);
    chk("rst_wdata", 32'(mem_wdata_out), 32'd0);
    chk("rst_wen", 32'(mem_wen_out), 32'd0);
    chk("rst_ren", 32'(mem_ren_out), 32'd0);
    chk("rst_wr_done", 32'(wr_done_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Write A7 to instruction memory address 5.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b0_0101_10100111, 13, -1, -1, -1);
    chk_deltas(w0, r0, e0, 1, 0, 0);
    chk("lit_wr_sel", 32'(cap_wsel), 32'd0);
    chk("lit_wr_addr", 32'(cap_waddr), 32'h5);
    chk("lit_wr_data", 32'(cap_wdata), 32'hA7);

    // Read data memory address 3 holding 3C.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b1, 16'b1_0011_00000000, 13, -1, -1, -1);
    chk_deltas(w0, r0, e0, 0, 1, 0);
    chk("lit_rd_sel", 32'(cap_rsel), 32'd1);
    chk("lit_rd_addr", 32'(cap_raddr), 32'h3);
    chk("lit_miso_word", 32'(miso_cap), 32'h3C);

    // Write cut after 3 data bits.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b0_0101_101, 8, -1, -1, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Both selects low mid-write.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b0_0110_11110000, 13, 6, -1, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Processor busy during command phase of a data write.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b1, 16'b0_0001_00110011, 13, -1, 3, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Processor busy already at frame start of a read.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b1_0101_00000000, 13, -1, 0, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Both selects fall together at frame start.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b1_0010_00000000, 13, 0, -1, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Overlong write frame (9 data bits).
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b0_0010_11110000_1, 14, -1, -1, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Read frame ending inside the command phase.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b1_01, 3, -1, -1, -1);
    chk_deltas(w0, r0, e0, 0, 0, 1);

    // Read frame cut after 3 data bits: no error.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b1_0010_000, 8, -1, -1, -1);
    chk_deltas(w0, r0, e0, 0, 1, 0);

    // Reset in the middle of a write, then a valid write.
    w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
    run_frame(1'b0, 16'b0_1010_11001100, 13, -1, -1, 8);
    run_frame(1'b0, 16'b0_1111_00000001, 13, -1, -1, -1);
    chk_deltas(w0, r0, e0, 1, 0, 0);
    chk("lit_rst_wr_addr", 32'(cap_waddr), 32'hF);
    chk("lit_rst_wr_data", 32'(cap_wdata), 32'h01);

    // Data memory write then read back.
    run_frame(1'b1, 16'b0_0111_01011010, 13, -1, -1, -1);
    run_frame(1'b1, 16'b1_0111_00000000, 13, -1, -1, -1);
    chk("lit_readback", 32'(miso_cap), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_port.md
SPI_MEM_PORT -- requirements
Module: spi_mem_port

Interface
REQ-001 Parameter DATA_W, default 8, memory word width in bits.
REQ-002 Parameter ADDR_W, default 4, memory address width; each target memory holds 2^ADDR_W words.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sck_in  input  1  SPI clock from master, asynchronous to clk.
REQ-006 mosi_in  input  1  serial data from master, MSB first.
REQ-007 csi_n_in  input  1  active-low chip select, instruction memory target.
REQ-008 csd_n_in  input  1  active-low chip select, data memory target.
REQ-009 miso_out  output  1  serial read data to master, MSB first.
REQ-010 proc_busy_in  input  1  processor running; memory access forbidden.
REQ-011 mem_sel_out  output  1  target select: 0 = instruction memory, 1 = data memory.
REQ-012 mem_addr_out  output  ADDR_W  memory address.
REQ-013 mem_wdata_out  output  DATA_W  memory write data.
REQ-014 mem_wen_out  output  1  one-cycle write strobe.
REQ-015 mem_ren_out  output  1  one-cycle read strobe.
REQ-016 mem_rdata_in  input  DATA_W  read data, valid exactly 1 cycle after mem_ren_out.
REQ-017 wr_done_out  output  1  one-cycle pulse on write commit.
REQ-018 err_out  output  1  one-cycle pulse on frame rejection.
REQ-019 busy_out  output  1  high while the FSM is not in IDLE.

Function
REQ-020 sck_in, csi_n_in, csd_n_in and mosi_in SHALL each pass a 2-flop synchronizer; edges are detected on synchronized values.
REQ-021 A frame SHALL start on the falling edge of (csi_n & csd_n); mem_sel is latched then as csi_n high.
REQ-022 Frame format SHALL be 1 R/W bit (1 = read), ADDR_W address bits, DATA_W data bits, all sampled on synchronized sck rising edges.
REQ-023 FSM states SHALL be IDLE, CMD, WDATA, RDATA, COMMIT, DRAIN.
REQ-024 IDLE->CMD on frame start; CMD->WDATA or RDATA after 1+ADDR_W bits per the R/W bit.
REQ-025 Entering RDATA SHALL pulse mem_ren_out for one cycle; the returned word SHALL load the TX shift register on the next cycle.
REQ-026 In RDATA, miso_out SHALL present the TX MSB and shift on each synchronized sck falling edge; miso_out is 0 outside RDATA.
REQ-027 WDATA->COMMIT on chip-select deassertion with exactly DATA_W data bits received; COMMIT pulses mem_wen_out and wr_done_out together, then ->IDLE.
REQ-028 A write frame ending with fewer than DATA_W data bits SHALL pulse err_out and perform no write.
REQ-029 More than DATA_W data bits SHALL move the FSM to DRAIN; at chip-select deassertion err_out pulses and no write occurs.
REQ-030 A read frame ending at any point after mem_ren_out SHALL return to IDLE without error; a read frame ending in CMD SHALL pulse err_out.
REQ-031 Both chip selects low at the same time in any state SHALL cause DRAIN and, at deassertion, an err_out pulse with no memory access.
REQ-032 proc_busy_in high at frame start or at any point in a frame SHALL cause DRAIN, with no mem_wen_out or mem_ren_out, and an err_out pulse at deassertion.
REQ-033 DRAIN SHALL wait for both chip selects high, then ->IDLE.
REQ-034 Bit counter SHALL be wide enough for 1+ADDR_W+DATA_W+1 and SHALL saturate, not wrap.
REQ-035 mem_addr_out, mem_wdata_out and mem_sel_out SHALL hold their values from the end of the frame until the next frame start.

Reset
REQ-036 On rst: FSM=IDLE, counter=0, shift registers=0, all outputs 0, synchronizer chip-select flops=1.
REQ-037 A frame in progress at reset SHALL be dropped with no write and no error; the next frame SHALL require a fresh chip-select falling edge.

Structure
REQ-038 State encoding and the R/W bit position constant SHALL live in the shared package; DATA_W/ADDR_W defaults come from the existing datapath width and memory size macros.
REQ-039 One sub-module, spi_sync (2-flop synchronizer with rise/fall edge outputs), SHALL be used for the SPI inputs.

Verification (DATA_W=8, ADDR_W=4, sck period 8 clk)
REQ-040 csi frame 0,0101,10100111 -> one mem_wen_out with sel=0, addr=5, wdata=A7; wr_done_out with it; no err_out.
REQ-041 csd read frame 1,0011 with memory word 3C -> one mem_ren_out with sel=1, addr=3; miso bits 0,0,1,1,1,1,0,0.
REQ-042 csi write frame cut after 3 data bits -> err_out pulse; no mem_wen_out.
REQ-043 csi and csd both low during a frame, or proc_busy_in high mid-frame -> err_out pulse after deassertion; no memory strobes.
REQ-044 rst pulse during WDATA, then a valid write 0,1111,00000001 -> only the second frame writes addr=F, wdata=01.
